// File: rtl/iter_divider_pkg.sv
// Shared constants for the iterative divider: default width, FSM encoding and result packing.
package iter_divider_pkg;

    localparam int DIV_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Result word is {quotient, remainder}; offsets given for the default width.
    localparam int QUO_LSB = DIV_W;
    localparam int REM_LSB = 0;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, evaluated one bit wider than the operand so that
// the most negative value yields its true magnitude when read as unsigned.
module div_sign_fix
    import iter_divider_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] val_i,
    input  logic         sext_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    logic [W:0] ext;

    assign ext   = {sext_i & val_i[W-1], val_i};
    assign res_o = neg_i ? W'(-ext) : W'(ext);

endmodule

// File: rtl/iter_divider.sv
// Radix-2 restoring divider with independent divisor/dividend capture and a one-cycle result strobe.
//   state   | meaning
//   IDLE    | collecting operands; each tready high until its channel is captured
//   CALC    | WIDTH shift/trial-subtract iterations on operand magnitudes
//   DONE    | result strobe for one cycle, capture flags cleared
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH  = DIV_W,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    output logic               m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

    localparam int CNT_W = 6;

    logic [1:0]         state_q, state_d;
    logic               dvs_flag_q, dvs_flag_d;
    logic               dvd_flag_q, dvd_flag_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_mag_q, dvs_mag_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [2*WIDTH-1:0] dout_q, dout_d;

    logic               dvs_hs, dvd_hs, both_in;
    logic [WIDTH-1:0]   dvs_in, dvd_in;
    logic               dvs_neg, dvd_neg;
    logic [WIDTH-1:0]   dvs_mag, dvd_mag;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic               fit;
    logic [WIDTH-1:0]   rem_nxt, quo_nxt;
    logic [WIDTH-1:0]   q_fix, r_fix;

    // Gating with reset keeps both treadys low while reset is held.
    assign s_axis_divisor_tready  = !reset && (state_q == ST_IDLE) && !dvs_flag_q;
    assign s_axis_dividend_tready = !reset && (state_q == ST_IDLE) && !dvd_flag_q;
    assign m_axis_dout_tvalid     = (state_q == ST_DONE);
    assign m_axis_dout_tdata      = dout_q;

    assign dvs_hs  = s_axis_divisor_tvalid && s_axis_divisor_tready;
    assign dvd_hs  = s_axis_dividend_tvalid && s_axis_dividend_tready;
    assign both_in = (dvs_flag_q || dvs_hs) && (dvd_flag_q || dvd_hs);

    // Operands arriving this cycle bypass their registers so CALC can start on the next edge.
    assign dvs_in  = dvs_hs ? s_axis_divisor_tdata  : dvs_q;
    assign dvd_in  = dvd_hs ? s_axis_dividend_tdata : dvd_q;
    assign dvs_neg = SIGNED && dvs_in[WIDTH-1];
    assign dvd_neg = SIGNED && dvd_in[WIDTH-1];

    div_sign_fix #(.W(WIDTH)) u_dvs_mag (.val_i(dvs_in), .sext_i(SIGNED), .neg_i(dvs_neg), .res_o(dvs_mag));
    div_sign_fix #(.W(WIDTH)) u_dvd_mag (.val_i(dvd_in), .sext_i(SIGNED), .neg_i(dvd_neg), .res_o(dvd_mag));

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_mag_q};
    assign fit     = !diff[WIDTH+1];
    assign rem_nxt = fit ? WIDTH'(diff) : WIDTH'(shifted);
    assign quo_nxt = {quo_q[WIDTH-2:0], fit};

    div_sign_fix #(.W(WIDTH)) u_quo_fix (.val_i(quo_nxt), .sext_i(1'b0), .neg_i(q_neg_q), .res_o(q_fix));
    div_sign_fix #(.W(WIDTH)) u_rem_fix (.val_i(rem_nxt), .sext_i(1'b0), .neg_i(r_neg_q), .res_o(r_fix));

    always_comb begin
        state_d    = state_q;
        dvs_flag_d = dvs_flag_q;
        dvd_flag_d = dvd_flag_q;
        dvs_d      = dvs_q;
        dvd_d      = dvd_q;
        dvs_mag_d  = dvs_mag_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dout_d     = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (dvs_hs) begin
                    dvs_flag_d = 1'b1;
                    dvs_d      = s_axis_divisor_tdata;
                end
                if (dvd_hs) begin
                    dvd_flag_d = 1'b1;
                    dvd_d      = s_axis_dividend_tdata;
                end
                if (both_in) begin
                    state_d   = ST_CALC;
                    dvs_mag_d = dvs_mag;
                    quo_d     = dvd_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    q_neg_d   = dvd_neg ^ dvs_neg;
                    r_neg_d   = dvd_neg;
                end
            end
            ST_CALC: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d                 = ST_DONE;
                    dout_d[REM_LSB +: WIDTH] = r_fix;
                    dout_d[WIDTH +: WIDTH]   = q_fix;
                end
            end
            ST_DONE: begin
                dvs_flag_d = 1'b0;
                dvd_flag_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dvs_flag_q <= 1'b0;
            dvd_flag_q <= 1'b0;
            dvs_q      <= '0;
            dvd_q      <= '0;
            dvs_mag_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            dvs_flag_q <= dvs_flag_d;
            dvd_flag_q <= dvd_flag_d;
            dvs_q      <= dvs_d;
            dvd_q      <= dvd_d;
            dvs_mag_q  <= dvs_mag_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dout_q     <= dout_d;
        end
    end

endmodule
